// File: rtl/ntt_pkg.sv
// ntt_pkg: shared widths, moduli and payload types for the NTT datapath.
//   DATA_WIDTH_DFLT : default coefficient/modulus width
//   TAG_WIDTH_DFLT  : default sideband tag width
//   PROD_W          : width of a*b
//   RED_W           : width of the Barrett remainder before final correction
//   Q_* / MU_*      : supported moduli with mu = floor(2^(2*DATA_WIDTH)/q)
package ntt_pkg;

  localparam int unsigned DATA_WIDTH_DFLT = 16;
  localparam int unsigned TAG_WIDTH_DFLT  = 8;
  localparam int unsigned PROD_W          = 2 * DATA_WIDTH_DFLT;
  localparam int unsigned RED_W           = DATA_WIDTH_DFLT + 2;
  localparam int unsigned MU_WIDTH_DFLT   = PROD_W;

  localparam logic [DATA_WIDTH_DFLT-1:0] Q_3329  = 16'd3329;
  localparam logic [MU_WIDTH_DFLT-1:0]   MU_3329 = 32'd1290167;
  localparam logic [DATA_WIDTH_DFLT-1:0] Q_7681  = 16'd7681;
  localparam logic [MU_WIDTH_DFLT-1:0]   MU_7681 = 32'd559167;

  // Result payload at the default widths (tag travels with the data).
  typedef struct packed {
    logic [TAG_WIDTH_DFLT-1:0]  tag;
    logic [DATA_WIDTH_DFLT-1:0] data;
  } ntt_res_t;

endpackage

// File: rtl/barrett_mul_pipe_if.sv
// barrett_mul_pipe_if: operand/result handshake bundle of the Barrett multiplier.
//   modulus, mu           : quasi-static reduction constants (change only while busy=0)
//   in_valid/in_ready     : operand handshake, carrying in_a, in_b, in_tag
//   out_valid/out_ready   : result handshake, carrying out_data, out_tag
//   busy                  : any pipeline stage holds a valid entry
// master = operand source / result sink, slave = the multiplier.
interface barrett_mul_pipe_if
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DFLT,
  parameter int unsigned TAG_WIDTH  = TAG_WIDTH_DFLT,
  parameter int unsigned MU_WIDTH   = 2 * DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] modulus;
  logic [MU_WIDTH-1:0]   mu;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic [TAG_WIDTH-1:0]  in_tag;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TAG_WIDTH-1:0]  out_tag;

  logic                  busy;

  modport master (
    output modulus, mu,
    output in_valid, in_a, in_b, in_tag,
    input  in_ready,
    input  out_valid, out_data, out_tag,
    output out_ready,
    input  busy
  );

  modport slave (
    input  modulus, mu,
    input  in_valid, in_a, in_b, in_tag,
    output in_ready,
    output out_valid, out_data, out_tag,
    input  out_ready,
    output busy
  );

endinterface

// File: rtl/barrett_reduce.sv
// barrett_reduce: stages S2..S4 of the Barrett modular multiplier.
//   S2: qh = (p*mu) >> PROD_WIDTH, p forwarded
//   S3: r  = p - qh*q, evaluated modulo 2^RED_WIDTH (0 <= r < 3q)
//   S4: conditional subtraction of 2q or q, result registered
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   adv_i           : pipeline advance (low = global stall, every stage holds)
//   valid_i, p_i    : S1 valid bit and product a*b
//   tag_i           : S1 sideband tag
//   modulus_i, mu_i : reduction constants
//   valid_o, data_o : S4 valid bit and reduced result
//   tag_o           : tag of the S4 entry
//   busy_o          : any of S2..S4 holds a valid entry
module barrett_reduce
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DFLT,
  parameter int unsigned TAG_WIDTH  = TAG_WIDTH_DFLT,
  parameter int unsigned MU_WIDTH   = 2 * DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    adv_i,
  input  logic                    valid_i,
  input  logic [2*DATA_WIDTH-1:0] p_i,
  input  logic [TAG_WIDTH-1:0]    tag_i,
  input  logic [DATA_WIDTH-1:0]   modulus_i,
  input  logic [MU_WIDTH-1:0]     mu_i,
  output logic                    valid_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [TAG_WIDTH-1:0]    tag_o,
  output logic                    busy_o
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int unsigned RED_WIDTH  = DATA_WIDTH + 2;
  localparam int unsigned MUL_WIDTH  = PROD_WIDTH + MU_WIDTH;

  // S2 registers. Only the low RED_WIDTH bits of qh and p matter downstream,
  // because S3 works modulo 2^RED_WIDTH.
  logic                  v2_q,   v2_d;
  logic [RED_WIDTH-1:0]  qh2_q,  qh2_d;
  logic [RED_WIDTH-1:0]  p2_q,   p2_d;
  logic [TAG_WIDTH-1:0]  tag2_q, tag2_d;

  // S3 registers
  logic                  v3_q,   v3_d;
  logic [RED_WIDTH-1:0]  r3_q,   r3_d;
  logic [TAG_WIDTH-1:0]  tag3_q, tag3_d;

  // S4 registers (the block outputs)
  logic                  v4_q,   v4_d;
  logic [DATA_WIDTH-1:0] res4_q, res4_d;
  logic [TAG_WIDTH-1:0]  tag4_q, tag4_d;

  // q and 2q widened to the remainder width; q < 2^(DATA_WIDTH-1) so 2q fits.
  logic [RED_WIDTH-1:0]  q_ext;
  logic [RED_WIDTH-1:0]  q2_ext;

  assign q_ext  = RED_WIDTH'(modulus_i);
  assign q2_ext = RED_WIDTH'({modulus_i, 1'b0});

  // Next-state for all three stages; everything holds while adv_i is low.
  // Data registers only load behind a valid entry to keep them quiet.
  always_comb begin
    v2_d   = v2_q;
    qh2_d  = qh2_q;
    p2_d   = p2_q;
    tag2_d = tag2_q;
    v3_d   = v3_q;
    r3_d   = r3_q;
    tag3_d = tag3_q;
    v4_d   = v4_q;
    res4_d = res4_q;
    tag4_d = tag4_q;

    if (adv_i) begin
      v2_d = valid_i;
      if (valid_i) begin
        qh2_d  = RED_WIDTH'((MUL_WIDTH'(p_i) * MUL_WIDTH'(mu_i)) >> PROD_WIDTH);
        p2_d   = RED_WIDTH'(p_i);
        tag2_d = tag_i;
      end

      v3_d = v2_q;
      if (v2_q) begin
        // Exact as long as the true remainder is below 3q < 2^RED_WIDTH.
        r3_d   = p2_q - RED_WIDTH'(qh2_q * q_ext);
        tag3_d = tag2_q;
      end

      v4_d = v3_q;
      if (v3_q) begin
        if (r3_q >= q2_ext) begin
          res4_d = DATA_WIDTH'(r3_q - q2_ext);
        end else if (r3_q >= q_ext) begin
          res4_d = DATA_WIDTH'(r3_q - q_ext);
        end else begin
          res4_d = DATA_WIDTH'(r3_q);
        end
        tag4_d = tag3_q;
      end
    end
  end

  // Stage registers; reset clears every valid bit immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      qh2_q  <= '0;
      p2_q   <= '0;
      tag2_q <= '0;
      v3_q   <= 1'b0;
      r3_q   <= '0;
      tag3_q <= '0;
      v4_q   <= 1'b0;
      res4_q <= '0;
      tag4_q <= '0;
    end else begin
      v2_q   <= v2_d;
      qh2_q  <= qh2_d;
      p2_q   <= p2_d;
      tag2_q <= tag2_d;
      v3_q   <= v3_d;
      r3_q   <= r3_d;
      tag3_q <= tag3_d;
      v4_q   <= v4_d;
      res4_q <= res4_d;
      tag4_q <= tag4_d;
    end
  end

  assign valid_o = v4_q;
  assign data_o  = res4_q;
  assign tag_o   = tag4_q;
  assign busy_o  = v2_q | v3_q | v4_q;

endmodule

// File: rtl/barrett_mul_pipe.sv
// barrett_mul_pipe: 4-stage pipelined (a*b) mod q using Barrett reduction,
// one result per cycle, valid/ready handshake with a global stall.
//   S1 (here)            : p = a*b, tag and valid registered alongside
//   S2..S4 (reduce core) : quotient estimate, remainder, final correction
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset, drops all in-flight entries
//   bus   : slave side of barrett_mul_pipe_if (operands, results, busy)
// Stall = out_valid & ~out_ready; in_ready is its complement, so the whole
// pipe either advances together or holds together.
module barrett_mul_pipe
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DFLT,
  parameter int unsigned TAG_WIDTH  = TAG_WIDTH_DFLT,
  parameter int unsigned MU_WIDTH   = 2 * DATA_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  barrett_mul_pipe_if.slave   bus
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

  logic                  stall;
  logic                  adv;

  logic                  v1_q,   v1_d;
  logic [PROD_WIDTH-1:0] p1_q,   p1_d;
  logic [TAG_WIDTH-1:0]  tag1_q, tag1_d;

  logic                  red_valid;
  logic [DATA_WIDTH-1:0] red_data;
  logic [TAG_WIDTH-1:0]  red_tag;
  logic                  red_busy;

  // Only an unaccepted result can block the pipe.
  assign stall = red_valid & ~bus.out_ready;
  assign adv   = ~stall;

  // S1 next-state: a transfer in happens whenever the pipe advances with in_valid.
  always_comb begin
    v1_d   = v1_q;
    p1_d   = p1_q;
    tag1_d = tag1_q;
    if (adv) begin
      v1_d = bus.in_valid;
      if (bus.in_valid) begin
        p1_d   = PROD_WIDTH'(bus.in_a) * PROD_WIDTH'(bus.in_b);
        tag1_d = bus.in_tag;
      end
    end
  end

  // S1 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      p1_q   <= '0;
      tag1_q <= '0;
    end else begin
      v1_q   <= v1_d;
      p1_q   <= p1_d;
      tag1_q <= tag1_d;
    end
  end

  barrett_reduce #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH),
    .MU_WIDTH   (MU_WIDTH)
  ) u_reduce (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv_i     (adv),
    .valid_i   (v1_q),
    .p_i       (p1_q),
    .tag_i     (tag1_q),
    .modulus_i (bus.modulus),
    .mu_i      (bus.mu),
    .valid_o   (red_valid),
    .data_o    (red_data),
    .tag_o     (red_tag),
    .busy_o    (red_busy)
  );

  assign bus.in_ready  = adv;
  assign bus.out_valid = red_valid;
  assign bus.out_data  = red_data;
  assign bus.out_tag   = red_tag;
  assign bus.busy      = v1_q | red_busy;

endmodule
